writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter DEPTH, default 4, writeback queue entries (power of two).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports alu_valid (in, 1), alu_ready (out, 1), alu_rd (in, 5), alu_result (in, XLEN), for the ALU result source.
REQ-006 SHALL have ports mem_valid (in, 1), mem_ready (out, 1), mem_rd (in, 5), mem_data (in, XLEN, raw aligned word), mem_funct3 (in, 3, load type), mem_offset (in, 2, byte address bits [1:0]), for the load result source.
REQ-007 SHALL have port wb_stall, input, 1, which blocks draining while high.
REQ-008 SHALL have ports write_reg (out, 5), write_enable (out, 1) and write_data (out, XLEN), which drive the register-file write port.
REQ-009 SHALL have port count, output, clog2(DEPTH)+1, current queue occupancy.

Function
REQ-010 SHALL accept a source in the cycle where its valid and ready are both high at the rising edge, and SHALL accept at most one entry per cycle.
REQ-011 SHALL drive mem_ready = !full and alu_ready = !full && !mem_valid, giving the load source fixed priority.
REQ-012 SHALL keep alu_valid/mem_valid independent of ready; a source that is held off SHALL keep its payload stable, and the block SHALL NOT drop it.
REQ-013 SHALL format load data at enqueue: LB (000) and LH (001) sign-extend; LW (010) passes the word; LBU (100) and LHU (101) zero-extend.
REQ-014 SHALL select the byte/half as byte = mem_data[8*offset +: 8] and half = mem_data[16*offset[1] +: 16], ignoring offset[0] for halves.
REQ-015 SHALL treat any other funct3 as LW.
REQ-016 SHALL pop the queue head at each edge where count>0 and wb_stall=0, and SHALL register it onto write_reg/write_data with write_enable = (rd != 0).
REQ-017 SHALL otherwise drive write_enable = 0 for one cycle, while write_reg/write_data hold their last values.
REQ-018 SHALL give a latency from accept edge N on an empty queue with no stall to write_enable high of the interval between edge N+1 and edge N+2.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and preserve order.
REQ-020 SHALL provide throughput of 1 entry/cycle sustained.
REQ-021 SHALL, when full, hold both readies low; a pop in that cycle SHALL NOT allow a same-cycle push (no ready-from-pop combinational path).
REQ-022 SHALL wrap read/write pointers modulo DEPTH; count SHALL distinguish full (DEPTH) from empty (0).
REQ-023 SHALL write entries to the register file strictly in acceptance order.
REQ-024 SHALL accept rd=0 entries, which consume a slot and produce a cycle with write_enable=0.

Reset
REQ-025 SHALL, with reset high at an edge, clear pointers and set count=0, write_enable=0, write_reg=0 and write_data=0.
REQ-026 SHALL discard queued entries on reset mid-operation, with no register-file write after that edge.
REQ-027 SHALL force alu_ready and mem_ready to 0 while reset is high.
REQ-028 SHALL give reset priority over wb_stall and over push.

Structure
REQ-029 SHALL take XLEN, REG_ADDR_W=5 and the load funct3 codes (LB, LH, LW, LBU, LHU) from the shared package riscv_pkg.
REQ-030 SHALL implement the queue as sub-module wb_fifo: synchronous, parameterized width/depth, with push/pop/full/empty/count.
REQ-031 SHALL implement arbitration, load formatting and output registers in writeback_unit.

Verification
REQ-032 SHALL cover single ALU write: alu_valid, rd=5, result 0x0000_00AB at edge 1 -> write_enable=1, write_reg=5, write_data=0xAB between edges 2 and 3.
REQ-033 SHALL cover load extension: mem_data 0x80FF_7F01 with LB off 3 -> 0xFFFF_FF80; LBU off 1 -> 0x7F; LH off 2 -> 0xFFFF_80FF; LHU off 0 -> 0x7F01; LW -> 0x80FF_7F01.
REQ-034 SHALL cover simultaneous sources: both valid in one cycle -> mem accepted, alu_ready=0, ALU accepted next cycle, writes appear mem then ALU on consecutive cycles.
REQ-035 SHALL cover stall/full: wb_stall=1 and 5 ALU pushes -> count reaches 4, alu_ready=0; release stall -> 4 writes in order, then 5th.
REQ-036 SHALL cover x0: rd=0 value 0x1234 -> write_enable stays 0, count returns to 0.
REQ-037 SHALL cover reset mid-operation: count=3 under stall, reset for one edge -> count=0, write_enable=0, no later writes of old entries.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V datapath widths and load funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO with occupancy count; head is read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (c_AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Arbitrates ALU/load results into a queue and drains it to the
//               register-file write port, formatting load data on entry.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                 alu_result,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]                 mem_data,
  input  logic [2:0]                      mem_funct3,
  input  logic [1:0]                      mem_offset,
  input  logic                            wb_stall,
  output logic [riscv_pkg::REG_ADDR_W-1:0] write_reg,
  output logic                            write_enable,
  output logic [XLEN-1:0]                 write_data,
  output logic [$clog2(DEPTH):0]          count
);

  import riscv_pkg::*;

  localparam int c_ENTRY_W = REG_ADDR_W + XLEN;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_take_mem;
  logic                  w_take_alu;
  logic                  w_push;
  logic                  w_pop;
  logic [XLEN-1:0]       w_load_data;
  logic [c_ENTRY_W-1:0]  w_push_data;
  logic [c_ENTRY_W-1:0]  w_head;
  logic [REG_ADDR_W-1:0] w_head_rd;

  logic [REG_ADDR_W-1:0] r_write_reg;
  logic                  r_write_enable;
  logic [XLEN-1:0]       r_write_data;

  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0] data,
    input logic [2:0]      funct3,
    input logic [1:0]      offset
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = data[8*offset +: 8];
    h = data[16*offset[1] +: 16];
    case (funct3)
      LB:      format_load = {{(XLEN-8){b[7]}}, b};
      LH:      format_load = {{(XLEN-16){h[15]}}, h};
      LBU:     format_load = {{(XLEN-8){1'b0}}, b};
      LHU:     format_load = {{(XLEN-16){1'b0}}, h};
      default: format_load = data;
    endcase
  endfunction

  // Readies depend only on registered fullness, never on this cycle's pop.
  assign mem_ready   = !reset && !w_full;
  assign alu_ready   = !reset && !w_full && !mem_valid;
  assign w_take_mem  = mem_valid && mem_ready;
  assign w_take_alu  = alu_valid && alu_ready;
  assign w_push      = w_take_mem || w_take_alu;
  assign w_load_data = format_load(mem_data, mem_funct3, mem_offset);
  assign w_push_data = w_take_mem ? {mem_rd, w_load_data} : {alu_rd, alu_result};
  assign w_pop       = !w_empty && !wb_stall;
  assign w_head_rd   = w_head[XLEN +: REG_ADDR_W];

  wb_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_reg    <= '0;
      r_write_data   <= '0;
      r_write_enable <= 1'b0;
    end else if (w_pop) begin
      r_write_reg    <= w_head_rd;
      r_write_data   <= w_head[XLEN-1:0];
      r_write_enable <= (w_head_rd != '0);
    end else begin
      r_write_enable <= 1'b0;
    end
  end

  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign write_enable = r_write_enable;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Directed vector table plus multi-cycle sequences for writeback_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_offset;
  logic        wb_stall;
  logic [4:0]  write_reg;
  logic        write_enable;
  logic [31:0] write_data;
  logic [2:0]  count;

  int n_cmp;
  int n_fail;

  logic [36:0] log_q[$];

  typedef struct {
    bit          use_mem;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  writeback_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_result   (alu_result),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_funct3   (mem_funct3),
    .mem_offset   (mem_offset),
    .wb_stall     (wb_stall),
    .write_reg    (write_reg),
    .write_enable (write_enable),
    .write_data   (write_data),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable === 1'b1) log_q.push_back({write_reg, write_data});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit use_mem, input logic [4:0] rd, input logic [31:0] d,
                      input logic [2:0] f3, input logic [1:0] off);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    if (use_mem) begin
      mem_valid = 1'b1; mem_rd = rd; mem_data = d; mem_funct3 = f3; mem_offset = off;
    end else begin
      alu_valid = 1'b1; alu_rd = rd; alu_result = d;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      acc = use_mem ? mem_ready : alu_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bit acc;
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; wb_stall = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; mem_funct3 = '0; mem_offset = '0;

    vecs[0] = '{0, 5'd5,  32'h0000_00AB, 3'b000, 2'd0, 1'b1, 32'h0000_00AB};
    vecs[1] = '{1, 5'd1,  32'h80FF_7F01, 3'b000, 2'd3, 1'b1, 32'hFFFF_FF80};
    vecs[2] = '{1, 5'd2,  32'h80FF_7F01, 3'b100, 2'd1, 1'b1, 32'h0000_007F};
    vecs[3] = '{1, 5'd3,  32'h80FF_7F01, 3'b001, 2'd2, 1'b1, 32'hFFFF_80FF};
    vecs[4] = '{1, 5'd4,  32'h80FF_7F01, 3'b101, 2'd0, 1'b1, 32'h0000_7F01};
    vecs[5] = '{1, 5'd6,  32'h80FF_7F01, 3'b010, 2'd0, 1'b1, 32'h80FF_7F01};
    vecs[6] = '{1, 5'd9,  32'h80FF_7F01, 3'b011, 2'd2, 1'b1, 32'h80FF_7F01};
    vecs[7] = '{1, 5'd11, 32'h1234_8765, 3'b001, 2'd1, 1'b1, 32'hFFFF_8765};
    vecs[8] = '{0, 5'd31, 32'hFFFF_FFFF, 3'b000, 2'd0, 1'b1, 32'hFFFF_FFFF};
    vecs[9] = '{0, 5'd0,  32'h0000_1234, 3'b000, 2'd0, 1'b0, 32'h0000_1234};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_reg", write_reg, 0);
    chk("rst_data", write_data, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    reset = 1'b0;

    // Vector table: single transaction, write one cycle after accept
    foreach (vecs[i]) begin
      push(vecs[i].use_mem, vecs[i].rd, vecs[i].data, vecs[i].f3, vecs[i].off);
      @(negedge clk);
      chk($sformatf("v%0d_we", i), write_enable, vecs[i].exp_we);
      chk($sformatf("v%0d_reg", i), write_reg, vecs[i].rd);
      chk($sformatf("v%0d_data", i), write_data, vecs[i].exp_data);
      @(negedge clk);
      chk($sformatf("v%0d_we_drop", i), write_enable, 0);
      chk($sformatf("v%0d_count", i), count, 0);
    end

    // Simultaneous sources: load wins, ALU follows
    @(negedge clk);
    log_q.delete();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1111_1111; mem_funct3 = 3'b010; mem_offset = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_result = 32'h2222_2222;
    #1;
    chk("sim_alu_ready", alu_ready, 0);
    chk("sim_mem_ready", mem_ready, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chk("sim_alu_ready2", alu_ready, 1);
    @(negedge clk);
    alu_valid = 1'b0;
    chk("sim_w1_we", write_enable, 1);
    chk("sim_w1_reg", write_reg, 7);
    chk("sim_w1_data", write_data, 32'h1111_1111);
    @(negedge clk);
    chk("sim_w2_we", write_enable, 1);
    chk("sim_w2_reg", write_reg, 8);
    chk("sim_w2_data", write_data, 32'h2222_2222);
    repeat (2) @(negedge clk);
    chk("sim_nwrites", log_q.size(), 2);

    // Stall until full, then drain in order
    log_q.delete();
    @(negedge clk);
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 5'(10 + k), 32'h100 + k, 3'b000, 2'd0);
    chk("full_count", count, 4);
    chk("full_alu_ready", alu_ready, 0);
    chk("full_mem_ready", mem_ready, 0);
    chk("stall_nwrites", log_q.size(), 0);
    alu_valid = 1'b1; alu_rd = 5'd14; alu_result = 32'h104;
    repeat (2) @(negedge clk);
    chk("full_hold_count", count, 4);
    chk("full_hold_ready", alu_ready, 0);
    wb_stall = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      acc = alu_ready;
      @(posedge clk);
      @(negedge clk);
    end
    alu_valid = 1'b0;
    chk("fifth_accepted", acc, 1);
    repeat (8) @(negedge clk);
    chk("drain_nwrites", log_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_q.size())
        chk($sformatf("drain_%0d", k), log_q[k], {5'(10 + k), 32'h100 + k});
    end
    chk("drain_count", count, 0);

    // Reset mid-operation discards queued entries
    @(negedge clk);
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) push(0, 5'(20 + k), 32'h200 + k, 3'b000, 2'd0);
    chk("mid_count", count, 3);
    log_q.delete();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd23; alu_result = 32'h203;
    #1;
    chk("mid_rst_alu_ready", alu_ready, 0);
    chk("mid_rst_mem_ready", mem_ready, 0);
    @(negedge clk);
    reset = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", write_enable, 0);
    repeat (6) @(negedge clk);
    chk("mid_no_writes", log_q.size(), 0);
    chk("mid_final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
